// File: rtl/block_memory_ctrl.sv
// Block-granular main-memory model and controller behind the write-back cache.
// Accepts one refill or write-back at a time, waits LATENCY cycles, then
// moves the four 32-bit words of the block one per cycle and pulses
// resp_valid. The word array has no reset so an abort leaves prior beats
// committed.
module block_memory_ctrl #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [127:0]      req_wdata,
    output logic              resp_valid,
    output logic [127:0]      resp_rdata,
    output logic              busy
);

    localparam int unsigned BlkW = ADDR_W - 4;
    localparam int unsigned IdxW = ADDR_W - 2;
    // Counter preload; with LATENCY=0 the wait state is skipped entirely.
    localparam logic [3:0] LatInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StXfer, StResp} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic              r_write;
    logic [BlkW-1:0]   r_blk;
    logic [127:0]      r_wdata;
    logic [127:0]      r_buf;
    logic [127:0]      r_rdata;
    logic [3:0]        r_cnt;
    logic [1:0]        r_beat;
    logic [31:0]       r_mem [MEM_WORDS];

    logic [IdxW-1:0]   w_idx;
    logic [31:0]       w_wword;
    logic [31:0]       w_rword;
    logic              w_unused_addr;

    assign w_idx         = {r_blk, r_beat};
    assign w_wword       = r_wdata[{r_beat, 5'd0} +: 32];
    assign w_rword       = r_mem[w_idx];
    // Byte offset within the block is irrelevant: transfers are block aligned.
    assign w_unused_addr = ^req_addr[3:0];

    assign req_ready  = (r_state == StIdle);
    assign busy       = ~req_ready;
    assign resp_valid = (r_state == StResp);
    assign resp_rdata = r_rdata;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic for IDLE -> WAIT -> XFER -> RESP -> IDLE.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (req_valid) begin
                    w_state_d = (LATENCY == 0) ? StXfer : StWait;
                end
            end
            StWait: begin
                if (r_cnt == 4'd0) begin
                    w_state_d = StXfer;
                end
            end
            StXfer: begin
                if (r_beat == 2'd3) begin
                    w_state_d = StResp;
                end
            end
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Request capture, wait/beat counters and read-block assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write <= 1'b0;
            r_blk   <= '0;
            r_wdata <= '0;
            r_buf   <= '0;
            r_rdata <= '0;
            r_cnt   <= 4'd0;
            r_beat  <= 2'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_blk   <= req_addr[ADDR_W-1:4];
                        r_wdata <= req_wdata;
                        r_cnt   <= LatInit;
                        r_beat  <= 2'd0;
                    end
                end
                StWait: begin
                    r_beat <= 2'd0;
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StXfer: begin
                    r_beat <= r_beat + 2'd1;
                    if (!r_write) begin
                        r_buf[{r_beat, 5'd0} +: 32] <= w_rword;
                        // Publish the whole block only as RESP is entered.
                        if (r_beat == 2'd3) begin
                            r_rdata <= {w_rword, r_buf[95:0]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Word array: one word written per XFER cycle on a write-back.
    always_ff @(posedge clk) begin
        if (r_state == StXfer && r_write) begin
            r_mem[w_idx] <= w_wword;
        end
    end

endmodule

// File: tb/tb_block_memory_ctrl.sv
// Scoreboard bench for block_memory_ctrl (LATENCY=4 main instance, plus a
// LATENCY=0 instance for the short-latency timing case).
module tb_block_memory_ctrl;

    localparam int Lat = 4;

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [9:0]   req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic         resp_valid;
    logic [127:0] resp_rdata;
    logic         busy;

    logic         z_req_valid = 1'b0;
    logic         z_req_ready;
    logic         z_req_write = 1'b0;
    logic [9:0]   z_req_addr = '0;
    logic [127:0] z_req_wdata = '0;
    logic         z_resp_valid;
    logic [127:0] z_resp_rdata;
    logic         z_busy;

    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           last_e0 = 0;
    int           pushed = 0;
    int           resps = 0;
    exp_t         sb_q[$];
    logic [31:0]  mem_m [256];
    logic [127:0] last_rd = '0;

    block_memory_ctrl #(.ADDR_W(10), .LATENCY(Lat), .MEM_WORDS(256)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .busy       (busy)
    );

    block_memory_ctrl #(.ADDR_W(10), .LATENCY(0), .MEM_WORDS(256)) u_dut_lat0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (z_req_valid),
        .req_ready  (z_req_ready),
        .req_write  (z_req_write),
        .req_addr   (z_req_addr),
        .req_wdata  (z_req_wdata),
        .resp_valid (z_resp_valid),
        .resp_rdata (z_resp_rdata),
        .busy       (z_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // Monitor: every resp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            resps++;
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 128'(cyc), 128'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("resp_rdata", resp_rdata, e.data);
                chk("resp_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    // Issue one request, holding req_valid until accepted; model the result.
    task automatic send(input logic wr, input logic [9:0] a, input logic [127:0] wd,
                        input bit gap);
        int   n;
        int   e0;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 128'(req_ready), 128'(1));
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e0 = cyc;
        // Scramble inputs: only the accepted values may matter.
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = ~a;
        req_wdata = ~wd;
        chk("ready_drops", 128'(req_ready), 128'(0));
        chk("busy_high", 128'(busy), 128'(1));
        // IDLE is re-entered after E(L+5); a held request is taken on the next edge.
        if (gap) chk("accept_gap", 128'(e0 - last_e0), 128'(Lat + 6));
        last_e0 = e0;
        for (int w = 0; w < 4; w++) begin
            if (wr) mem_m[{a[9:4], 2'(w)}] = wd[32*w +: 32];
        end
        if (!wr) begin
            for (int w = 0; w < 4; w++) last_rd[32*w +: 32] = mem_m[{a[9:4], 2'(w)}];
        end
        e.data = last_rd;
        e.cyc  = e0 + Lat + 4;
        sb_q.push_back(e);
        pushed++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || !req_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 128'(sb_q.size()), 128'(0));
        chk("rdata_held", resp_rdata, last_rd);
    endtask

    initial begin
        logic [127:0] pat;
        logic [127:0] pz;
        for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;

        // 1: reset values, then a read of block 0.
        #3;
        chk("rst_ready", 128'(req_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_resp_valid", 128'(resp_valid), 128'(0));
        chk("rst_rdata", resp_rdata, 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 10'h000, 128'(0), 1'b0);
        repeat (Lat + 5) @(posedge clk);
        #1;
        chk("ready_after_e9", 128'(req_ready), 128'(1));
        drain();

        // 2: write-back block 1 then read it via an unaligned address.
        send(1'b1, 10'h010, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0);
        drain();
        send(1'b0, 10'h01C, 128'(0), 1'b0);
        drain();

        // 3: top block, no aliasing onto block 0.
        pat = {32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1234_5678, 32'hA5A5_5A5A};
        send(1'b1, 10'h3F0, pat, 1'b0);
        drain();
        send(1'b0, 10'h3FF, 128'(0), 1'b0);
        drain();
        send(1'b0, 10'h000, 128'(0), 1'b0);
        drain();

        // 4: second request held while busy; accepted only once IDLE returns.
        send(1'b1, 10'h100, {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000}, 1'b0);
        send(1'b0, 10'h104, 128'(0), 1'b1);
        drain();

        // 5: reset after two XFER beats of an all-ones write to block 2.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 10'h020;
        req_wdata = {128{1'b1}};
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (Lat + 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 128'(req_ready), 128'(1));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_resp_valid", 128'(resp_valid), 128'(0));
        chk("abort_rdata", resp_rdata, 128'(0));
        mem_m[8] = 32'hFFFF_FFFF;
        mem_m[9] = 32'hFFFF_FFFF;
        last_rd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        send(1'b0, 10'h020, 128'(0), 1'b0);
        drain();
        chk("resp_count", 128'(resps), 128'(pushed));

        // 6: LATENCY=0 instance, write then held back-to-back read.
        pz = {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};
        @(negedge clk);
        chk("lat0_ready", 128'(z_req_ready), 128'(1));
        z_req_valid = 1'b1;
        z_req_write = 1'b1;
        z_req_addr  = 10'h050;
        z_req_wdata = pz;
        @(posedge clk);
        #1;
        z_req_write = 1'b0;
        z_req_wdata = '0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("lat0_resp_k%0d", k), 128'(z_resp_valid), 128'(k == 4 || k == 10));
            if (k == 6) z_req_valid = 1'b0;
            if (k == 10) chk("lat0_rdata", z_resp_rdata, pz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
